// File: rtl/controle_rodadas_jogo.sv
// Round/move sequencing controller for the memory game: walks the sequence
// address, grows the round, times each move and reports win/loss/timeout.
module controle_rodadas_jogo #(
  parameter int N_JOGADAS      = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              jogar,
  input  logic              jogada_feita,
  input  logic              jogada_correta,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              registra,
  output logic              pronto,
  output logic              ganhou,
  output logic              perdeu,
  output logic              timeout,
  output logic [3:0]        db_estado
);

  // Wide enough to hold TIMEOUT_CICLOS, the value reached on the expiry edge.
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [ADDR_W-1:0] ULTIMA_RODADA = ADDR_W'(N_JOGADAS - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h3,
    COMPARA     = 4'h4,
    PROX_JOGADA = 4'h5,
    PROX_RODADA = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_ERRO    = 4'hE,
    FIM_TIMEOUT = 4'hD
  } estado_t;

  estado_t           r_estado;
  estado_t           w_prox;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_rodada;
  logic [TW-1:0]     r_timer;
  logic              w_expirou;

  assign w_expirou = (r_timer == TW'(TIMEOUT_CICLOS - 1));

  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      INICIAL:     if (jogar) w_prox = PREPARA;
      PREPARA:     w_prox = ESPERA;
      ESPERA: begin
        if (jogada_feita)   w_prox = REGISTRA;
        else if (w_expirou) w_prox = FIM_TIMEOUT;
      end
      REGISTRA:    w_prox = COMPARA;
      COMPARA: begin
        if (!jogada_correta)                w_prox = FIM_ERRO;
        else if (r_endereco != r_rodada)    w_prox = PROX_JOGADA;
        else if (r_rodada == ULTIMA_RODADA) w_prox = FIM_ACERTO;
        else                                w_prox = PROX_RODADA;
      end
      PROX_JOGADA: w_prox = ESPERA;
      PROX_RODADA: w_prox = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (jogar) w_prox = PREPARA;
      default:     w_prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado   <= INICIAL;
      r_endereco <= '0;
      r_rodada   <= '0;
      r_timer    <= '0;
    end else begin
      r_estado <= w_prox;
      case (r_estado)
        PREPARA: begin
          r_endereco <= '0;
          r_rodada   <= '0;
          r_timer    <= '0;
        end
        ESPERA:      r_timer <= r_timer + TW'(1);
        PROX_JOGADA: begin
          r_endereco <= r_endereco + ADDR_W'(1);
          r_timer    <= '0;
        end
        PROX_RODADA: begin
          r_rodada   <= r_rodada + ADDR_W'(1);
          r_endereco <= '0;
          r_timer    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign endereco  = r_endereco;
  assign rodada    = r_rodada;
  assign db_estado = r_estado;
  assign registra  = (r_estado == REGISTRA);
  assign ganhou    = (r_estado == FIM_ACERTO);
  assign timeout   = (r_estado == FIM_TIMEOUT);
  assign perdeu    = (r_estado == FIM_ERRO) || (r_estado == FIM_TIMEOUT);
  assign pronto    = (r_estado == FIM_ACERTO) || perdeu;

endmodule

// File: tb/tb_controle_rodadas_jogo.sv
// Self-checking bench for controle_rodadas_jogo: randomized games checked
// against a move-level model of the game rules.
module tb_controle_rodadas_jogo;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int T  = 5000;

  logic          clock = 1'b0;
  logic          reset;
  logic          jogar;
  logic          jogada_feita;
  logic          jogada_correta;
  logic [AW-1:0] endereco;
  logic [AW-1:0] rodada;
  logic          registra, pronto, ganhou, perdeu, timeout;
  logic [3:0]    db_estado;

  int checks = 0;
  int errors = 0;
  int m_e = 0;
  int m_r = 0;

  logic [16:0] act;
  assign act = {db_estado, pronto, ganhou, perdeu, timeout, registra, endereco, rodada};

  controle_rodadas_jogo #(
    .N_JOGADAS(N),
    .ADDR_W(AW),
    .TIMEOUT_CICLOS(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .jogar(jogar),
    .jogada_feita(jogada_feita),
    .jogada_correta(jogada_correta),
    .endereco(endereco),
    .rodada(rodada),
    .registra(registra),
    .pronto(pronto),
    .ganhou(ganhou),
    .perdeu(perdeu),
    .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected output vector for a given state code and address/round.
  function automatic logic [16:0] expv(input logic [3:0] st, input int e, input int r);
    logic fim;
    logic perde;
    perde = (st == 4'hE) || (st == 4'hD);
    fim   = perde || (st == 4'hA);
    return {st, fim, st == 4'hA, perde, st == 4'hD, st == 4'h3, e[3:0], r[3:0]};
  endfunction

  task automatic start_game();
    jogar = 1'b1;
    tick();
    checks++;
    if (act !== expv(4'h1, m_e, m_r)) begin
      errors++;
      $display("FAIL start_prepara: got %h expected %h", act, expv(4'h1, m_e, m_r));
    end
    tick();
    jogar = 1'b0;
    m_e = 0;
    m_r = 0;
    checks++;
    if (act !== expv(4'h2, 0, 0)) begin
      errors++;
      $display("FAIL start_espera: got %h expected %h", act, expv(4'h2, 0, 0));
    end
  endtask

  // res: 0 game continues, 1 won, 2 lost
  task automatic play_move(input int p, input int r, input bit ok, input int dly, output int res);
    for (int i = 0; i < dly; i++) begin
      jogar          = 1'($urandom % 2);
      jogada_correta = 1'($urandom % 2);
      tick();
    end
    jogar = 1'b0;
    checks++;
    if (act !== expv(4'h2, p, r)) begin
      errors++;
      $display("FAIL move_espera p%0d r%0d: got %h expected %h", p, r, act, expv(4'h2, p, r));
    end
    jogada_feita = 1'b1;
    tick();
    jogada_feita   = 1'b0;
    jogada_correta = ok;
    checks++;
    if (act !== expv(4'h3, p, r)) begin
      errors++;
      $display("FAIL move_registra p%0d r%0d: got %h expected %h", p, r, act, expv(4'h3, p, r));
    end
    jogada_feita = 1'($urandom % 2);
    tick();
    jogada_feita = 1'b0;
    checks++;
    if (act !== expv(4'h4, p, r)) begin
      errors++;
      $display("FAIL move_compara p%0d r%0d: got %h expected %h", p, r, act, expv(4'h4, p, r));
    end
    tick();
    jogada_correta = 1'($urandom % 2);
    if (!ok) begin
      res = 2;
      checks++;
      if (act !== expv(4'hE, p, r)) begin
        errors++;
        $display("FAIL move_erro p%0d r%0d: got %h expected %h", p, r, act, expv(4'hE, p, r));
      end
      m_e = p;
      m_r = r;
    end else if (p < r) begin
      res = 0;
      checks++;
      if (act !== expv(4'h5, p, r)) begin
        errors++;
        $display("FAIL move_prox_jogada p%0d r%0d: got %h expected %h", p, r, act, expv(4'h5, p, r));
      end
      tick();
      m_e = p + 1;
      m_r = r;
    end else if (r == N - 1) begin
      res = 1;
      checks++;
      if (act !== expv(4'hA, p, r)) begin
        errors++;
        $display("FAIL move_acerto p%0d r%0d: got %h expected %h", p, r, act, expv(4'hA, p, r));
      end
      m_e = p;
      m_r = r;
    end else begin
      res = 0;
      checks++;
      if (act !== expv(4'h6, p, r)) begin
        errors++;
        $display("FAIL move_prox_rodada p%0d r%0d: got %h expected %h", p, r, act, expv(4'h6, p, r));
      end
      tick();
      m_e = 0;
      m_r = r + 1;
    end
  endtask

  task automatic test_end_hold(input logic [3:0] st);
    for (int i = 0; i < 4; i++) begin
      jogada_feita   = 1'($urandom % 2);
      jogada_correta = 1'($urandom % 2);
      tick();
      checks++;
      if (act !== expv(st, m_e, m_r)) begin
        errors++;
        $display("FAIL end_hold %h: got %h expected %h", st, act, expv(st, m_e, m_r));
      end
    end
    jogada_feita = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (act !== expv(4'h0, 0, 0)) begin
      errors++;
      $display("FAIL reset: got %h expected %h", act, expv(4'h0, 0, 0));
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (act !== expv(4'h0, 0, 0)) begin
        errors++;
        $display("FAIL reset_idle: got %h expected %h", act, expv(4'h0, 0, 0));
      end
    end
  endtask

  task automatic test_full_game();
    int res;
    start_game();
    jogar = 1'b1;
    repeat (3) tick();
    jogar = 1'b0;
    for (int r = 0; r < N; r++)
      for (int p = 0; p <= r; p++)
        play_move(p, r, 1'b1, int'($urandom_range(0, 5)), res);
    test_end_hold(4'hA);
  endtask

  task automatic test_wrong_move();
    int res;
    start_game();
    play_move(0, 0, 1'b1, 2, res);
    play_move(0, 1, 1'b1, 1, res);
    play_move(1, 1, 1'b0, 3, res);
    test_end_hold(4'hE);
  endtask

  task automatic test_restart_from_erro();
    start_game();
  endtask

  task automatic test_timeout();
    int res;
    repeat (T - 1) tick();
    checks++;
    if (act !== expv(4'h2, 0, 0)) begin
      errors++;
      $display("FAIL timeout_before: got %h expected %h", act, expv(4'h2, 0, 0));
    end
    tick();
    checks++;
    if (act !== expv(4'hD, 0, 0)) begin
      errors++;
      $display("FAIL timeout_expiry: got %h expected %h", act, expv(4'hD, 0, 0));
    end
    test_end_hold(4'hD);
    start_game();
    // press on the expiry cycle; the move must win over the timeout
    play_move(0, 0, 1'b1, T - 1, res);
    // timer must restart after each move
    play_move(0, 1, 1'b1, T - 1, res);
  endtask

  task automatic test_reset_mid();
    int res;
    play_move(1, 1, 1'b1, 0, res);
    for (int p = 0; p <= 2; p++) play_move(p, 2, 1'b1, 1, res);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_e = 0;
    m_r = 0;
    checks++;
    if (act !== expv(4'h0, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", act, expv(4'h0, 0, 0));
    end
    jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0;
    tick();
    checks++;
    if (act !== expv(4'h0, 0, 0)) begin
      errors++;
      $display("FAIL reset_ignore_jogada: got %h expected %h", act, expv(4'h0, 0, 0));
    end
  endtask

  task automatic test_random_games();
    int res;
    int p;
    int r;
    for (int g = 0; g < 6; g++) begin
      start_game();
      res = 0;
      r = 0;
      while (res == 0) begin
        for (p = 0; p <= r && res == 0; p++)
          play_move(p, r, ($urandom % 12) != 0, int'($urandom_range(0, 12)), res);
        r++;
      end
      test_end_hold(res == 1 ? 4'hA : 4'hE);
    end
  endtask

  initial begin
    reset          = 1'b0;
    jogar          = 1'b0;
    jogada_feita   = 1'b0;
    jogada_correta = 1'b0;
    test_reset();
    test_full_game();
    test_wrong_move();
    test_restart_from_erro();
    test_timeout();
    test_reset_mid();
    test_random_games();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_rodadas_jogo.md
Name: controle_rodadas_jogo

Overview:
- Sequencing controller for the memory-game datapath.
- The sequence grows by one position per round, for up to N_JOGADAS rounds.
- Drives the sequence-memory address, round counter and button-register strobe, and runs the per-move timeout.
- Declares win, loss or timeout; sits between the edge-detected button path / memory comparator and the top-level game outputs.

Parameters:
- N_JOGADAS, 16, number of rounds; the game is won after round N_JOGADAS-1 is completed.
- ADDR_W, 4, width of the address and round counters; must satisfy 2^ADDR_W >= N_JOGADAS.
- TIMEOUT_CICLOS, 5000, clock cycles allowed per move (5 s at 1 kHz).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising clock edge.
- jogar  in  1  start/restart request, level-sampled.
- jogada_feita  in  1  one-cycle pulse from the button edge detector.
- jogada_correta  in  1  comparator result (registered button == memory[endereco]); valid in COMPARA.
- endereco  out  ADDR_W  sequence-memory address (current position).
- rodada  out  ADDR_W  current round index (positions 0..rodada must be matched).
- registra  out  1  one-cycle strobe: datapath latches the buttons.
- pronto  out  1  high in any end state.
- ganhou  out  1  high in FIM_ACERTO.
- perdeu  out  1  high in FIM_ERRO or FIM_TIMEOUT.
- timeout  out  1  high in FIM_TIMEOUT.
- db_estado  out  4  state encoding, for debug.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state goes to INICIAL; endereco, rodada and the timeout counter go to 0.
  - All 1-bit outputs are 0.
  - Reset overrides everything, including mid-game and end states.
- State encoding (db_estado): INICIAL 0, PREPARA 1, ESPERA 2, REGISTRA 3, COMPARA 4, PROX_JOGADA 5, PROX_RODADA 6, FIM_ACERTO A, FIM_ERRO E, FIM_TIMEOUT D.
- INICIAL:
  - jogar=1 -> PREPARA.
  - Otherwise stay.
- PREPARA (1 cycle):
  - Clear endereco, rodada and the timeout counter.
  - -> ESPERA.
- ESPERA:
  - The timeout counter increments each cycle.
  - jogada_feita=1 -> REGISTRA; jogada_feita has priority over an expiry in the same cycle.
  - Counter == TIMEOUT_CICLOS-1 with no jogada_feita -> FIM_TIMEOUT.
- REGISTRA (1 cycle):
  - registra=1.
  - -> COMPARA.
- COMPARA (1 cycle), decided on jogada_correta:
  - jogada_correta=0 -> FIM_ERRO.
  - jogada_correta=1 and endereco != rodada -> PROX_JOGADA.
  - jogada_correta=1, endereco == rodada, rodada == N_JOGADAS-1 -> FIM_ACERTO.
  - jogada_correta=1, endereco == rodada, otherwise -> PROX_RODADA.
- PROX_JOGADA (1 cycle):
  - endereco += 1; clear the timeout counter.
  - -> ESPERA.
- PROX_RODADA (1 cycle):
  - rodada += 1; endereco = 0; clear the timeout counter.
  - -> ESPERA.
- End states (FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT):
  - Hold all outputs, endereco and rodada.
  - jogar=1 -> PREPARA, which starts a new game.
  - jogada_feita is ignored.
- Output rules:
  - All outputs are Moore-decoded from state or registers; no combinational input-to-output paths.
- Latency:
  - Move pulse to decision: 3 cycles (ESPERA -> REGISTRA -> COMPARA -> next state).
  - The new address is valid in the cycle ESPERA is re-entered.
- Ignored inputs:
  - jogada_feita outside ESPERA is ignored; no queuing.
  - jogar outside INICIAL and the end states is ignored.
- Counters:
  - No counter wraps in legal operation.
  - rodada saturates at N_JOGADAS-1 by construction.

Test Plan:
1. reset=0 for 1 cycle, then 10 idle cycles -> db_estado=0, all flags 0, endereco=0, rodada=0.
2. jogar=1 for 5 cycles; then correct moves 0001, 0010, 0100, ..., one growing round per iteration, for 16 rounds -> rodada steps 0..15; after the final correct move, ganhou=1, pronto=1, perdeu=0, db_estado=A.
3. Start, complete round 0, then in round 1 press a wrong button at position 1 -> perdeu=1, timeout=0, db_estado=E, endereco=1, rodada=1.
4. Start and press nothing -> FIM_TIMEOUT exactly TIMEOUT_CICLOS cycles after entering ESPERA; timeout=1, perdeu=1. Repeat with the press on the expiry cycle -> REGISTRA is taken instead.
5. From FIM_ERRO assert jogar -> PREPARA, then ESPERA with rodada=0, endereco=0, flags cleared.
6. reset=0 mid-round (state ESPERA, rodada=3) -> INICIAL on the next edge with all outputs at reset values; a jogada_feita pulse in INICIAL has no effect.
